nios2_jtag_debug_cmd_sync: RTL
==============================

// Module: nios2_jtag_debug_cmd_sync
// PURPOSE
//  Parametrised sysclk-side command bridge for the JTAG debug slave. Takes IR and DR
//  snapshots that the TCK-domain shift logic has updated, and synchronises them into clk
//  with a toggle handshake. Buffers the commands in a FWFT FIFO and decodes each
//  dequeued command into one-hot take_action/take_no_action strobes for the OCI
//  break, ocimem and trace logic.
//  Unlike the fixed 2-bit IR/38-bit DR slave, IR/DR widths, sync depth and buffering
//  are configurable, and commands are never silently lost.
// PARAMETERS
//  DATA_W       38  DR snapshot width; bit DATA_W-1 is the action bit
//  IR_W         2   IR width; strobe vectors are 2**IR_W wide
//  SYNC_STAGES  2   toggle synchroniser depth, legal >=2
//  FIFO_DEPTH   4   command FIFO entries, power of 2, >=2
// PORTS
//  clk             in   1                system clock
//  reset           in   1                async, active-high reset
//  udr_toggle      in   1                TCK domain; flips once per update-DR
//  ir_in           in   IR_W             TCK domain; stable >= SYNC_STAGES+2 clk after toggle
//  sr              in   DATA_W           TCK domain; same stability as ir_in
//  cmd_ready       in   1                consumer accepts head command
//  err_clr         in   1                clears sticky error flags
//  cmd_valid       out  1                FIFO non-empty
//  cmd_ir          out  IR_W             head IR (FWFT)
//  jdo             out  DATA_W           head DR (FWFT)
//  take_action     out  2**IR_W          one-hot strobe, pop with jdo[DATA_W-1]=1
//  take_no_action  out  2**IR_W          one-hot strobe, pop with jdo[DATA_W-1]=0
//  fifo_level      out  $clog2(FIFO_DEPTH+1)  occupied entries
//  overflow        out  1                sticky: command dropped because FIFO full
// BEHAVIOUR
//  - Reset (async assert, sync release): sync chain, delayed bit, FIFO pointers and
//    level, overflow and arm counter are cleared. cmd_valid=0, cmd_ir=0, jdo=0,
//    strobes=0, fifo_level=0.
//  - Arm: edge detect is masked for SYNC_STAGES+1 clk after reset release; the delayed
//    bit still tracks. A toggle level of 1 present at reset release does not create a
//    command.
//  - Detect: udr_toggle passes through SYNC_STAGES flops, then one delay flop.
//    edge = sync_out ^ delayed. A push happens on the clk edge where edge=1.
//  - Latency: cmd_valid rises after the (SYNC_STAGES+1)th rising clk edge that samples
//    the new toggle level. ir_in and sr are captured directly on the push edge (they are
//    quasi-static).
//  - Pop: cmd_valid & cmd_ready. Pop on empty is ignored.
//    On a pop cycle, take_action[cmd_ir] or take_no_action[cmd_ir] is 1, selected by
//    jdo[DATA_W-1]; both vectors are otherwise 0. They are combinational from the
//    registered head, so exactly one bit pulses per pop.
//  - Full: a push with no pop while fifo_level==FIFO_DEPTH is dropped, overflow sets,
//    and the level is unchanged. Push and pop in the same cycle while full is accepted
//    and the level is unchanged. Push and pop in the same cycle while empty is a normal
//    push; the pop is ignored.
//  - Pointers wrap modulo FIFO_DEPTH. fifo_level is a separate counter, +1 on push
//    only, -1 on pop only.
//  - err_clr clears overflow next edge; a simultaneous overflow event wins (flag stays 1).
//  - Reset mid-stream discards all queued commands. Toggles that occur during reset are
//    not replayed.
// CONFIGURATION
//  DBG_CMD_PARITY_EN defined:
//    - Adds input sr_parity (1 bit, TCK domain, same stability rule as sr) and output
//      perr (sticky).
//    - Commands are checked for odd parity over {sr_parity, ir_in, sr}.
//    - A failing command is not pushed and sets perr; it does not set overflow.
//    - err_clr clears perr with the same priority rule as overflow.
//  DBG_CMD_PARITY_EN undefined: sr_parity and perr are absent and every detected
//    command is pushed.
// TESTING
//  1 Reset release with udr_toggle=1, hold 20 clk -> cmd_valid=0, fifo_level=0.
//  2 SYNC_STAGES=2: toggle 0->1 with ir_in=2'b01, sr=38'h20_0000_00AB ->
//    cmd_valid=1 after 3rd sampling edge; cmd_ready=1 gives take_action=4'b0010 for
//    1 clk, jdo=38'h20_0000_00AB.
//  3 cmd_ready=0, 5 toggles (DEPTH=4) -> fifo_level=4, overflow=1; pops return first 4
//    in order; err_clr -> overflow=0.
//  4 FIFO full, cmd_ready=1 on the push-edge cycle -> level stays 4, overflow stays 0,
//    order is preserved.
//  5 jdo[37]=0, ir=2'b11 popped -> take_no_action=4'b1000, take_action=0.
//  6 PARITY_EN: bad sr_parity -> no push, perr=1; next good command is pushed normally.

Source files
------------

// File: rtl/nios2_jtag_debug_cmd_sync.sv
// Sysclk-side JTAG debug command bridge: toggle synchroniser, FWFT command FIFO and one-hot
// action strobes. Optional macro DBG_CMD_PARITY_EN adds odd-parity checking with sticky perr.
module nios2_jtag_debug_cmd_sync #(
    parameter int DATA_W      = 38,
    parameter int IR_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic                              i_udr_toggle,
    input  logic [IR_W-1:0]                   i_ir_in,
    input  logic [DATA_W-1:0]                 i_sr,
`ifdef DBG_CMD_PARITY_EN
    input  logic                              i_sr_parity,
    output logic                              o_perr,
`endif
    input  logic                              i_cmd_ready,
    input  logic                              i_err_clr,
    output logic                              o_cmd_valid,
    output logic [IR_W-1:0]                   o_cmd_ir,
    output logic [DATA_W-1:0]                 o_jdo,
    output logic [(2**IR_W)-1:0]              o_take_action,
    output logic [(2**IR_W)-1:0]              o_take_no_action,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_fifo_level,
    output logic                              o_overflow
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = $clog2(FIFO_DEPTH + 1);
    localparam int ARM_CNT = SYNC_STAGES + 1;
    localparam int ARM_W   = $clog2(SYNC_STAGES + 2);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_delayed;
    logic [ARM_W-1:0]       r_arm_cnt;
    logic [PTR_W-1:0]       r_wptr;
    logic [PTR_W-1:0]       r_rptr;
    logic [LVL_W-1:0]       r_level;
    logic                   r_overflow;
    logic [IR_W-1:0]        r_mem_ir [FIFO_DEPTH];
    logic [DATA_W-1:0]      r_mem_dr [FIFO_DEPTH];

    logic w_sync_out;
    logic w_armed;
    logic w_det;
    logic w_par_ok;
    logic w_push_req;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_ovf_evt;

`ifdef DBG_CMD_PARITY_EN
    logic r_perr;

    function automatic logic odd_parity_ok(input logic [DATA_W+IR_W:0] v);
        return ^v;
    endfunction

    assign w_par_ok = odd_parity_ok({i_sr_parity, i_ir_in, i_sr});
    assign o_perr   = r_perr;

    // Sticky parity error; a new failing command wins over err_clr.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_perr <= 1'b0;
        end else if (w_det && !w_par_ok) begin
            r_perr <= 1'b1;
        end else if (i_err_clr) begin
            r_perr <= 1'b0;
        end else begin
            r_perr <= r_perr;
        end
    end
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_armed    = (r_arm_cnt == ARM_W'(ARM_CNT));
    assign w_det      = (w_sync_out ^ r_delayed) & w_armed;
    assign w_push_req = w_det & w_par_ok;
    assign w_full     = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_pop      = o_cmd_valid & i_cmd_ready;
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_ovf_evt  = w_push_req & w_full & ~w_pop;

    // Toggle synchroniser, delay flop and post-reset arm counter.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync    <= '0;
            r_delayed <= 1'b0;
            r_arm_cnt <= '0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], i_udr_toggle};
            r_delayed <= w_sync_out;
            if (!w_armed) begin
                r_arm_cnt <= r_arm_cnt + ARM_W'(1);
            end else begin
                r_arm_cnt <= r_arm_cnt;
            end
        end
    end

    // FIFO pointers, occupancy counter and sticky overflow.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end else begin
                r_wptr <= r_wptr;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end else begin
                r_rptr <= r_rptr;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LVL_W'(1);
            end else begin
                r_level <= r_level;
            end
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end else if (i_err_clr) begin
                r_overflow <= 1'b0;
            end else begin
                r_overflow <= r_overflow;
            end
        end
    end

    // Command storage; IR/DR are quasi-static so they are captured on the push edge.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_ir[r_wptr] <= i_ir_in;
            r_mem_dr[r_wptr] <= i_sr;
        end
    end

    assign o_cmd_valid  = (r_level != '0);
    assign o_cmd_ir     = o_cmd_valid ? r_mem_ir[r_rptr] : '0;
    assign o_jdo        = o_cmd_valid ? r_mem_dr[r_rptr] : '0;
    assign o_fifo_level = r_level;
    assign o_overflow   = r_overflow;

    // One-hot strobe for the popped command, steered by the action bit.
    always_comb begin
        o_take_action    = '0;
        o_take_no_action = '0;
        if (w_pop) begin
            if (o_jdo[DATA_W-1]) begin
                o_take_action[o_cmd_ir] = 1'b1;
            end else begin
                o_take_no_action[o_cmd_ir] = 1'b1;
            end
        end else begin
            o_take_action    = '0;
            o_take_no_action = '0;
        end
    end

endmodule
